// File: rtl/incr_seq_driver.sv
// incr_seq_driver
//   Count sequencer wrapped around an external combinational incrementer.
//   Holds the count register and presents it to the incrementer (inc_a).
//   Takes the incrementer result (inc_result) as the next count candidate.
//   Streams each count value downstream over a valid/ready handshake.
//   Also provides start/stop/load control, wrap-or-halt at LIMIT, a
//   saturating wrap counter and a sticky incrementer-result check.
//
// Ports
//   clk, rst_n            clock, synchronous active-low reset
//   start, stop           begin/resume sequencing; return to IDLE at next transfer
//   load_en, load_val     load count (IDLE/DONE only), clamped to LIMIT
//   wrap_en               1: wrap to 0 after LIMIT, 0: halt in DONE
//   inc_a / inc_result    incrementer operand / result
//   out_valid, out_ready  downstream handshake
//   out_count             current count
//   done                  halted at LIMIT
//   wrap_cnt              number of wraps (saturating)
//   inc_err               sticky incrementer mismatch flag
module incr_seq_driver #(
  parameter int WIDTH = 3,
  parameter int LIMIT = 2**WIDTH - 1,
  parameter int WRAPW = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic             load_en,
  input  logic [WIDTH-1:0] load_val,
  input  logic             wrap_en,
  output logic [WIDTH-1:0] inc_a,
  input  logic [WIDTH-1:0] inc_result,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_count,
  output logic             done,
  output logic [WRAPW-1:0] wrap_cnt,
  output logic             inc_err
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  localparam logic [WIDTH-1:0] LIMIT_V = WIDTH'(LIMIT);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WRAPW-1:0] wrap_cnt_q, wrap_cnt_d;
  logic             inc_err_q, inc_err_d;
  logic             stop_pend_q, stop_pend_d;

  logic [WIDTH-1:0] load_clamp;
  logic [WIDTH-1:0] count_plus1;
  logic             xfer;
  logic             stop_req;

  assign load_clamp  = (load_val > LIMIT_V) ? LIMIT_V : load_val;
  assign count_plus1 = count_q + 1'b1;
  assign xfer        = (state_q == S_RUN) && out_ready;
  assign stop_req    = stop_pend_q || stop;

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    wrap_cnt_d  = wrap_cnt_q;
    inc_err_d   = inc_err_q;
    stop_pend_d = stop_pend_q;

    case (state_q)
      S_IDLE: begin
        stop_pend_d = 1'b0;
        if (load_en) count_d = load_clamp;
        if (start)   state_d = S_RUN;
      end

      S_RUN: begin
        if (xfer) begin
          if (count_q == LIMIT_V) begin
            if (wrap_en) begin
              count_d = '0;
              if (wrap_cnt_q != '1) wrap_cnt_d = wrap_cnt_q + 1'b1;
            end else begin
              state_d = S_DONE;
            end
          end else begin
            count_d = inc_result;
            if (inc_result != count_plus1) inc_err_d = 1'b1;
          end
          // A pending stop completes on this transfer; DONE outranks IDLE.
          if (stop_req && (state_d != S_DONE)) state_d = S_IDLE;
          stop_pend_d = 1'b0;
        end else begin
          stop_pend_d = stop_req;
        end
      end

      S_DONE: begin
        stop_pend_d = 1'b0;
        if (start) begin
          count_d = load_en ? load_clamp : '0;
          state_d = S_RUN;
        end else if (load_en) begin
          count_d = load_clamp;
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d     = S_IDLE;
        stop_pend_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      count_q     <= '0;
      wrap_cnt_q  <= '0;
      inc_err_q   <= 1'b0;
      stop_pend_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      wrap_cnt_q  <= wrap_cnt_d;
      inc_err_q   <= inc_err_d;
      stop_pend_q <= stop_pend_d;
    end
  end

  assign inc_a     = count_q;
  assign out_count = count_q;
  assign out_valid = (state_q == S_RUN);
  assign done      = (state_q == S_DONE);
  assign wrap_cnt  = wrap_cnt_q;
  assign inc_err   = inc_err_q;

endmodule

// File: doc/incr_seq_driver.md
Name: incr_seq_driver

Overview:
- Sequential count-sequencer that sits directly around the `incr_3bits` combinational incrementer.
- It holds the current count register and drives the incrementer's `A` input. It consumes `incrA` as next-count candidate.
- It emits the count stream to downstream logic over a valid/ready handshake.
- It adds start/stop/load control, terminal-count wrap-or-halt, a wrap counter, and a sticky check that the incrementer result is correct.

Parameters:
- WIDTH, 3, count width; must match the incrementer width.
- LIMIT, 2**WIDTH-1, terminal count value (0 < LIMIT <= 2**WIDTH-1).
- WRAPW, 8, width of the wrap counter.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  synchronous, active-low reset.
- start  input  1  begin or resume sequencing.
- stop  input  1  request return to IDLE at the next transfer.
- load_en  input  1  load count from load_val (IDLE/DONE only).
- load_val  input  WIDTH  load value; values > LIMIT clamp to LIMIT.
- wrap_en  input  1  1 = wrap to 0 after LIMIT; 0 = halt in DONE.
- inc_a  output  WIDTH  operand to the incrementer; equals the count register (combinational).
- inc_result  input  WIDTH  incrementer output (A+1 mod 2**WIDTH).
- out_valid  output  1  out_count is valid.
- out_ready  input  1  downstream accepts.
- out_count  output  WIDTH  current count.
- done  output  1  halted at LIMIT.
- wrap_cnt  output  WRAPW  number of wraps; saturates at all-ones.
- inc_err  output  1  sticky: inc_result mismatch seen.

Behaviour:
- Reset (rst_n=0 at edge): state IDLE, count=0, out_valid=0, done=0, wrap_cnt=0, inc_err=0, stop_pend=0. Reset overrides all other inputs in any state.
- inc_a = count at all times. out_count = count at all times. A transfer occurs when out_valid && out_ready.
- IDLE:
  - out_valid=0.
  - load_en: count<=clamp(load_val).
  - start: next state RUN; out_valid=1 from the next cycle.
  - start and load_en together: RUN begins with the loaded value.
- RUN:
  - out_valid=1. start and load_en are ignored.
  - No transfer: count and out_valid stay stable.
  - Transfer, count != LIMIT: count<=inc_result.
  - Transfer, count == LIMIT, wrap_en=1: count<=0; wrap_cnt+1 (saturating); stay in RUN.
  - Transfer, count == LIMIT, wrap_en=0: next state DONE; count holds LIMIT.
- stop in RUN:
  - Sets stop_pend.
  - At the first transfer in the same cycle or later: the count advances as above, then state goes IDLE and stop_pend clears.
  - If that transfer also hits LIMIT with wrap_en=0, DONE takes priority over IDLE.
  - out_valid never drops without a transfer.
- DONE:
  - out_valid=0, done=1.
  - start: count<=0, done<=0, RUN.
  - load_en: count<=clamp(load_val), done<=0, IDLE.
  - load_en and start together: count<=clamp(load_val), RUN.
- Incrementer check:
  - On every advance to inc_result, if inc_result != (count+1) mod 2**WIDTH, set inc_err<=1. Only reset clears it.
  - count still takes inc_result.
  - No check is made on wrap-to-0 or on load.
- Latency: start to first out_valid is 1 cycle. Transfer to next out_count is 1 cycle, giving full throughput of one value per cycle with out_ready held high.
- Reset mid-RUN with out_valid high: out_valid=0 on the cycle after the reset edge. No partial transfer is recorded.

Test Plan:
1. Halt mode: WIDTH=3, LIMIT=7, wrap_en=0, out_ready=1, pulse start; real `incr_3bits` connected -> out_count 0,1,…,7 on 8 consecutive valid cycles, then out_valid=0, done=1, out_count=7, inc_err=0.
2. Wrap mode: wrap_en=1, out_ready=1 for 10 transfers -> sequence 0..7,0,1; wrap_cnt=1 after the 8th transfer.
3. Backpressure: out_ready=0 for 3 cycles while out_count=3 -> out_valid=1, out_count=3 held all 3 cycles; 4 appears the cycle after out_ready=1.
4. Load+start: in IDLE assert load_en with load_val=5 and start together -> outputs 5,6,7, then DONE. Separately, load_val=6 with LIMIT=4 -> count clamps to 4.
5. Stop pending: stop pulse at out_count=2 with out_ready=0 -> valid stays high with 2. On out_ready=1, value 2 transfers; next cycle IDLE, out_valid=0, count=3.
6. Fault/reset: bench forces inc_result=0 at count=4 -> inc_err=1 next cycle, count=0. Then rst_n=0 for 1 cycle mid-RUN -> all outputs return to reset values, including inc_err=0.
